// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing asynchronous inputs into the clk domain.
// Reset value is a parameter so each bit can settle to its idle level.
module sync_2ff #(
   parameter int              WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // NOTE: both stages reset to the idle level so no false edge is seen when reset is released.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/spi_flash_id_responder.sv
// SPI mode-0 responder answering the flash ID commands 0x90 and 0x9F,
// oversampling SS/SCK/MOSI on the system clock.
module spi_flash_id_responder #(
   parameter logic [7:0]  MANUF_ID  = 8'hEF,
   parameter logic [7:0]  DEVICE_ID = 8'h17,
   parameter logic [15:0] JEDEC_ID  = 16'h4018
) (
   input  logic       rstn,
   input  logic       clk,
   input  logic       spi_ss,
   input  logic       spi_sck,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic       spi_miso_oe,
   output logic       cmd_valid,
   output logic [7:0] cmd,
   output logic       id_done
);

   localparam logic [7:0] CMD_READ_ID  = 8'h90;
   localparam logic [7:0] CMD_JEDEC_ID = 8'h9F;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] CMD    = 3'd1;
   localparam logic [2:0] ADDR   = 3'd2;
   localparam logic [2:0] DATA   = 3'd3;
   localparam logic [2:0] IGNORE = 3'd4;

   logic [2:0] sync_q;
   logic       ss_s, sck_s, mosi_s;

   sync_2ff #(
      .WIDTH     (3),
      .RESET_VAL (3'b100)
   ) u_sync (
      .clk  (clk),
      .rstn (rstn),
      .d    ({spi_ss, spi_sck, spi_mosi}),
      .q    (sync_q)
   );

   assign {ss_s, sck_s, mosi_s} = sync_q;

   logic       ss_d, sck_d;
   logic [1:0] warm;
   logic       armed;

   // A select that is already low when reset ends must not count as a falling edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ss_d  <= 1'b1;
         sck_d <= 1'b0;
         warm  <= 2'd0;
         armed <= 1'b0;
      end else begin
         ss_d  <= ss_s;
         sck_d <= sck_s;
         if (warm != 2'd2) warm <= warm + 2'd1;
         if (warm == 2'd2 && ss_s) armed <= 1'b1;
      end
   end

   logic ss_fall, ss_rise, sck_rise, sck_fall;

   // SCK edges while the synchronized select is high, including one coinciding with its rise, are dropped.
   assign ss_fall  = armed & ss_d & ~ss_s;
   assign ss_rise  = ~ss_d & ss_s;
   assign sck_rise = ~sck_d & sck_s & ~ss_s;
   assign sck_fall = sck_d & ~sck_s & ~ss_s;

   function automatic logic [7:0] id_byte(input logic jedec_cmd, input logic [1:0] idx);
      logic [7:0] b;
      b = 8'hFF;
      if (jedec_cmd) begin
         case (idx)
            2'd0:    b = MANUF_ID;
            2'd1:    b = JEDEC_ID[15:8];
            2'd2:    b = JEDEC_ID[7:0];
            default: b = 8'hFF;
         endcase
      end else begin
         b = idx[0] ? DEVICE_ID : MANUF_ID;
      end
      return b;
   endfunction

   logic [2:0] state;
   logic [4:0] bit_cnt;
   logic [1:0] byte_idx;
   logic [6:0] rx_sh;
   logic [7:0] tx_sh;
   logic       miso_r;
   logic       jedec;

   logic [7:0] cmd_byte;
   logic [1:0] next_idx;
   logic [7:0] next_byte;

   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      cmd_byte = {rx_sh, mosi_s};
      next_idx = 2'd0;
      if (jedec) next_idx = (byte_idx == 2'd3) ? 2'd3 : byte_idx + 2'd1;
      else       next_idx = {1'b0, ~byte_idx[0]};
      next_byte = id_byte(jedec, next_idx);
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         bit_cnt   <= 5'd0;
         byte_idx  <= 2'd0;
         rx_sh     <= 7'd0;
         tx_sh     <= 8'd0;
         miso_r    <= 1'b1;
         jedec     <= 1'b0;
         cmd       <= 8'h00;
         cmd_valid <= 1'b0;
         id_done   <= 1'b0;
      end else begin
         cmd_valid <= 1'b0;
         id_done   <= 1'b0;
         if (ss_rise) begin
            state    <= IDLE;
            bit_cnt  <= 5'd0;
            byte_idx <= 2'd0;
            rx_sh    <= 7'd0;
            tx_sh    <= 8'd0;
            miso_r   <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (ss_fall) begin
                     state   <= CMD;
                     bit_cnt <= 5'd0;
                     rx_sh   <= 7'd0;
                  end
               end
               CMD: begin
                  if (sck_rise) begin
                     rx_sh   <= cmd_byte[6:0];
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd7) begin
                        cmd       <= cmd_byte;
                        cmd_valid <= 1'b1;
                        bit_cnt   <= 5'd0;
                        byte_idx  <= 2'd0;
                        jedec     <= (cmd_byte == CMD_JEDEC_ID);
                        if (cmd_byte == CMD_READ_ID) begin
                           state <= ADDR;
                        end else if (cmd_byte == CMD_JEDEC_ID) begin
                           state <= DATA;
                           tx_sh <= id_byte(1'b1, 2'd0);
                        end else begin
                           state <= IGNORE;
                        end
                     end
                  end
               end
               ADDR: begin
                  if (sck_rise) begin
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd23) begin
                        state    <= DATA;
                        bit_cnt  <= 5'd0;
                        byte_idx <= 2'd0;
                        tx_sh    <= id_byte(jedec, 2'd0);
                     end
                  end
               end
               DATA: begin
                  // bit_cnt counts bits already driven in the current byte; at 8 the byte is complete.
                  if (sck_fall) begin
                     if (bit_cnt == 5'd8) begin
                        id_done  <= 1'b1;
                        byte_idx <= next_idx;
                        miso_r   <= next_byte[7];
                        tx_sh    <= {next_byte[6:0], 1'b0};
                        bit_cnt  <= 5'd1;
                     end else begin
                        miso_r  <= tx_sh[7];
                        tx_sh   <= {tx_sh[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 5'd1;
                     end
                  end
               end
               IGNORE: begin
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign spi_miso_oe = (state == DATA) & ~ss_s;
   assign spi_miso    = spi_miso_oe ? miso_r : 1'b1;

endmodule

// File: tb/tb_spi_flash_id_responder.sv
// Directed bench for spi_flash_id_responder: a bit-banged SPI master at 3 MHz
// against a 27 MHz system clock, checked against a byte-level response model.
`timescale 1ns/1ps
module tb_spi_flash_id_responder;

   localparam real CLK_HALF = 18.519;
   localparam real SCK_HALF = 166.667;

   localparam logic [7:0] MANUF     = 8'hEF;
   localparam logic [7:0] DEVICE    = 8'h17;
   localparam logic [7:0] JEDEC_TYP = 8'h40;
   localparam logic [7:0] JEDEC_CAP = 8'h18;

   logic       clk      = 1'b0;
   logic       rstn     = 1'b0;
   logic       spi_ss   = 1'b1;
   logic       spi_sck  = 1'b0;
   logic       spi_mosi = 1'b0;
   logic       spi_miso;
   logic       spi_miso_oe;
   logic       cmd_valid;
   logic [7:0] cmd;
   logic       id_done;

   int vectors     = 0;
   int miscompares = 0;
   int cv_total    = 0;
   int idd_total   = 0;
   int oe_total    = 0;
   logic [7:0] exp_cmd  = 8'h00;
   logic [7:0] last_cmd = 8'h00;
   logic [7:0] rx_q[$];

   spi_flash_id_responder #(
      .MANUF_ID  (MANUF),
      .DEVICE_ID (DEVICE),
      .JEDEC_ID  ({JEDEC_TYP, JEDEC_CAP})
   ) dut (
      .rstn        (rstn),
      .clk         (clk),
      .spi_ss      (spi_ss),
      .spi_sck     (spi_sck),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe),
      .cmd_valid   (cmd_valid),
      .cmd         (cmd),
      .id_done     (id_done)
   );

   always #(CLK_HALF) clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Byte n of the response a master clocks out after command c.
   function automatic logic [7:0] model_byte(input logic [7:0] c, input int n);
      if (c == 8'h90) return (n % 2 == 0) ? MANUF : DEVICE;
      if (c == 8'h9F) begin
         if (n == 0) return MANUF;
         if (n == 1) return JEDEC_TYP;
         if (n == 2) return JEDEC_CAP;
         return 8'hFF;
      end
      return 8'hFF;
   endfunction

   task automatic spi_bit(input logic mo, output logic mi);
      spi_mosi = mo;
      #(SCK_HALF);
      spi_sck = 1'b1;
      mi = spi_miso;
      #(SCK_HALF);
      spi_sck = 1'b0;
   endtask

   task automatic run_xfer(input logic [7:0] c, input int n_cmd, input int n_addr,
                           input int n_data, input string tag);
      int         cv0, idd0, oe0, exp_idd;
      logic       mi, is_id;
      logic [7:0] b;
      cv0 = cv_total;
      idd0 = idd_total;
      oe0 = oe_total;
      exp_cmd = c;
      rx_q.delete();
      b = 8'h00;
      spi_ss = 1'b0;
      #(SCK_HALF);
      for (int i = 0; i < n_cmd; i++) spi_bit(c[7-i], mi);
      for (int i = 0; i < n_addr; i++) spi_bit(1'b0, mi);
      for (int i = 0; i < n_data; i++) begin
         spi_bit(1'b0, mi);
         b = {b[6:0], mi};
         if (i % 8 == 7) rx_q.push_back(b);
      end
      #(SCK_HALF);
      spi_ss = 1'b1;
      #(2 * SCK_HALF);
      is_id = (n_cmd == 8) && ((c == 8'h90) || (c == 8'h9F));
      exp_idd = is_id ? n_data / 8 : 0;
      check({tag, " cmd_valid_count"}, 32'(cv_total - cv0), (n_cmd == 8) ? 32'd1 : 32'd0);
      check({tag, " id_done_count"}, 32'(idd_total - idd0), 32'(exp_idd));
      check({tag, " oe_seen"}, 32'(oe_total != oe0), 32'(is_id && n_data > 0));
      check({tag, " oe_after_ss"}, 32'(spi_miso_oe), 32'd0);
      for (int i = 0; i < rx_q.size(); i++)
         check($sformatf("%s byte%0d", tag, i), 32'(rx_q[i]), 32'(model_byte(c, i)));
   endtask

   initial begin
      #(2_000_000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         cv0, idd0, oe0;
      logic       mi;
      logic [7:0] b;

      fork
         forever begin
            @(negedge clk);
            if (!rstn) begin
               last_cmd = 8'h00;
            end else begin
               if (!spi_miso_oe) check("miso_idle_high", 32'(spi_miso), 32'd1);
               if (cmd_valid) begin
                  check("cmd_value", 32'(cmd), 32'(exp_cmd));
                  last_cmd = cmd;
                  cv_total++;
               end else begin
                  check("cmd_hold", 32'(cmd), 32'(last_cmd));
               end
               if (id_done) idd_total++;
               if (spi_miso_oe) oe_total++;
            end
         end
      join_none

      #(100);
      check("reset miso", 32'(spi_miso), 32'd1);
      check("reset oe", 32'(spi_miso_oe), 32'd0);
      check("reset cmd_valid", 32'(cmd_valid), 32'd0);
      check("reset cmd", 32'(cmd), 32'h00);
      check("reset id_done", 32'(id_done), 32'd0);
      rstn = 1'b1;
      repeat (5) @(posedge clk);
      #(SCK_HALF);

      run_xfer(8'h90, 8, 24, 16, "rdid16");
      check("rdid16 lit byte0", 32'(rx_q[0]), 32'hEF);
      check("rdid16 lit byte1", 32'(rx_q[1]), 32'h17);
      check("rdid16 lit cmd", 32'(cmd), 32'h90);

      run_xfer(8'h9F, 8, 0, 32, "jedec32");
      check("jedec32 lit byte0", 32'(rx_q[0]), 32'hEF);
      check("jedec32 lit byte1", 32'(rx_q[1]), 32'h40);
      check("jedec32 lit byte2", 32'(rx_q[2]), 32'h18);
      check("jedec32 lit byte3", 32'(rx_q[3]), 32'hFF);

      run_xfer(8'h90, 8, 24, 48, "rdid48");
      check("rdid48 lit byte4", 32'(rx_q[4]), 32'hEF);
      check("rdid48 lit byte5", 32'(rx_q[5]), 32'h17);

      run_xfer(8'h05, 8, 0, 16, "other");
      check("other lit cmd", 32'(cmd), 32'h05);

      run_xfer(8'h9F, 5, 0, 0, "abort");
      check("abort lit cmd_kept", 32'(cmd), 32'h05);
      run_xfer(8'h9F, 8, 0, 8, "after_abort");
      check("after_abort lit byte0", 32'(rx_q[0]), 32'hEF);

      // Reset in the middle of a JEDEC ID read, select held low throughout.
      exp_cmd = 8'h9F;
      spi_ss = 1'b0;
      #(SCK_HALF);
      for (int i = 0; i < 8; i++) begin
         b = 8'h9F;
         spi_bit(b[7-i], mi);
      end
      for (int i = 0; i < 12; i++) spi_bit(1'b0, mi);
      #(40);
      rstn = 1'b0;
      #(1);
      check("midreset oe", 32'(spi_miso_oe), 32'd0);
      check("midreset miso", 32'(spi_miso), 32'd1);
      check("midreset cmd", 32'(cmd), 32'h00);
      #(200);
      rstn = 1'b1;
      repeat (4) @(posedge clk);
      cv0 = cv_total;
      idd0 = idd_total;
      oe0 = oe_total;
      for (int i = 0; i < 16; i++) begin
         spi_bit(1'b1, mi);
         check($sformatf("postreset miso bit%0d", i), 32'(mi), 32'd1);
      end
      #(SCK_HALF);
      check("postreset cmd_valid_count", 32'(cv_total - cv0), 32'd0);
      check("postreset id_done_count", 32'(idd_total - idd0), 32'd0);
      check("postreset oe_seen", 32'(oe_total != oe0), 32'd0);
      spi_ss = 1'b1;
      #(2 * SCK_HALF);
      run_xfer(8'h9F, 8, 0, 16, "fresh");
      check("fresh lit byte0", 32'(rx_q[0]), 32'hEF);
      check("fresh lit byte1", 32'(rx_q[1]), 32'h40);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spi_flash_id_responder.md
SPI_FLASH_ID_RESPONDER -- requirements
Module: spi_flash_id_responder

Interface
REQ-001 Parameter MANUF_ID, default 8'hEF: manufacturer ID byte returned by commands 0x90 and 0x9F.
REQ-002 Parameter DEVICE_ID, default 8'h17: device ID byte returned by command 0x90.
REQ-003 Parameter JEDEC_ID, default 16'h4018: memory type (high byte) and capacity (low byte) returned by 0x9F after MANUF_ID.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 spi_ss  input  1  SPI chip select, active low, asynchronous to clk.
REQ-007 spi_sck  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-008 spi_mosi  input  1  master-to-responder data, MSB first.
REQ-009 spi_miso  output  1  responder-to-master data, MSB first.
REQ-010 spi_miso_oe  output  1  MISO output enable; the top level builds the tristate from it.
REQ-011 cmd_valid  output  1  one-clk pulse when a command byte is complete.
REQ-012 cmd  output  8  last received command byte; held until the next cmd_valid.
REQ-013 id_done  output  1  one-clk pulse after the last bit of each ID byte is shifted out.

Function
REQ-014 spi_ss, spi_sck and spi_mosi SHALL each pass through a 2-flop synchronizer; edges are detected on the synchronized signals.
REQ-015 The block SHALL operate correctly when the SCK high and low phases are each at least 4 clk periods.
REQ-016 MOSI SHALL be sampled on the synchronized SCK rising edge; MISO SHALL change only on the synchronized SCK falling edge.
REQ-017 FSM states: IDLE, CMD, ADDR, DATA, IGNORE.
REQ-018 IDLE -> CMD on the spi_ss falling edge; the bit counter SHALL clear to 0.
REQ-019 CMD: after 8 rising edges, cmd and cmd_valid SHALL update in the same clk as the 8th sample. The next state is ADDR for 0x90, DATA for 0x9F, IGNORE otherwise.
REQ-020 ADDR: 24 address bits are received and discarded; the state becomes DATA on the 24th rising edge.
REQ-021 DATA for 0x90: output bytes SHALL be MANUF_ID, DEVICE_ID, MANUF_ID, DEVICE_ID, ... repeating while SCK runs.
REQ-022 DATA for 0x9F: output bytes SHALL be MANUF_ID, JEDEC_ID[15:8], JEDEC_ID[7:0], then 8'hFF indefinitely.
REQ-023 The MSB of the first data byte SHALL appear on spi_miso at the SCK falling edge that follows the last command or address rising edge, before the master's next rising edge.
REQ-024 spi_miso_oe SHALL be 1 only in DATA while spi_ss is low. spi_miso SHALL be 1 whenever spi_miso_oe is 0.
REQ-025 IGNORE: SCK/MOSI are ignored, spi_miso_oe = 0, and no pulses are produced until spi_ss rises.
REQ-026 id_done SHALL pulse on the falling edge that completes bit 0 of each byte, including 8'hFF filler bytes.
REQ-027 A spi_ss rising edge in any state SHALL return the FSM to IDLE within 3 clk.
  - Counters and shift register clear; spi_miso_oe falls.
  - A partial command byte SHALL NOT produce cmd_valid.
REQ-028 An SCK edge that coincides with a spi_ss rising edge (both in the same synchronized clk) SHALL be ignored.
REQ-029 The bit counter is 5 bits wide. The byte index is 2 bits, saturating at 3 for 0x9F and toggling between 0 and 1 for 0x90.

Reset
REQ-030 On rstn low:
  - FSM SHALL be IDLE; counters 0.
  - spi_miso = 1, spi_miso_oe = 0, cmd_valid = 0, cmd = 8'h00, id_done = 0.
  - Synchronizer flops SHALL reset to spi_ss = 1, spi_sck = 0, spi_mosi = 0.
REQ-031 After rstn is released while spi_ss is already low, the block SHALL stay in IDLE until a fresh spi_ss falling edge.

Structure
REQ-032 No shared package. The command codes 0x90 and 0x9F SHALL be local constants.
REQ-033 A single sub-module, sync_2ff (parameterized width, async active-low reset with a reset value parameter), SHALL implement the synchronizers.

Verification
REQ-034 The bench SHALL run with clk = 27 MHz and SCK = 3 MHz. It SHALL cover:
  - Send 0x90 + 0x000000, clock 16 bits -> MISO reads 0xEF, 0x17; cmd = 0x90; one cmd_valid, two id_done.
  - Send 0x9F, clock 32 bits -> MISO reads 0xEF, 0x40, 0x18, 0xFF.
  - Send 0x90, clock 48 bits -> MISO reads 0xEF, 0x17, 0xEF, 0x17, 0xEF, 0x17.
  - Send 0x05 -> cmd_valid with cmd = 0x05; spi_miso_oe stays 0 for 16 further bits; no id_done.
  - Raise spi_ss after 5 command bits, then send 0x9F -> no cmd_valid on the aborted transfer; the second transfer returns 0xEF first.
  - Assert rstn low mid-DATA -> spi_miso_oe = 0 and spi_miso = 1 immediately; no response until a new spi_ss falling edge.
